// File: rtl/cache_line_controller_pkg.sv
// Shared types and constants for the cache line miss sequencer.
package cache_line_controller_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WB   = 2'd1,
        FILL = 2'd2,
        DONE = 2'd3
    } clc_state_t;

    localparam int WORD_BITS = 32;
    localparam int LINE_BITS = 128;

    // Byte-offset width of a line holding 'words' 32-bit words.
    function automatic int offset_bits(input int words);
        return $clog2(words) + 2;
    endfunction

    localparam int OFFSET_W = offset_bits(LINE_BITS / WORD_BITS);

endpackage

// File: rtl/cache_line_controller_line_beat_counter.sv
// Beat counter for one line transfer: advances per accepted beat, wraps after
// the last word, and flags the last beat. Shared by writeback and refill.
module line_beat_counter #(
    parameter int WORDS = 4,
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             adv,
    output logic [CNT_W-1:0] cnt,
    output logic             last
);

    assign last = (cnt == CNT_W'(WORDS - 1));

    // Count accepted beats, wrapping to 0 after the final word of the line.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)   cnt <= '0;
        else if (adv) cnt <= last ? '0 : cnt + 1'b1;
    end

endmodule

// File: rtl/cache_line_controller.sv
// Miss-handling sequencer between the write-back cache and data memory.
// A miss writes back the dirty victim (if any), then refills the requested
// line one 32-bit beat at a time and installs it with a one-cycle strobe.
// Optional: define CACHE_LINE_CTRL_PERF_EN for saturating miss/writeback counters.
module cache_line_controller
    import cache_line_controller_pkg::*;
#(
    parameter  int ADDR_W     = 32,
    parameter  int LINE_WORDS = 4,
    localparam int OFF_W      = offset_bits(LINE_WORDS),
    localparam int CNT_W      = $clog2(LINE_WORDS),
    localparam int LW         = WORD_BITS * LINE_WORDS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic                  hit,
    input  logic                  dirty,
    input  logic [ADDR_W-OFF_W-1:0] victim_line_addr,
    input  logic [LW-1:0]         victim_line,
    output logic                  stall,
    output logic [LW-1:0]         fill_line,
    output logic                  fill_valid,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [WORD_BITS-1:0]  mem_wdata,
    output logic                  mem_req,
    output logic                  mem_we,
    input  logic [WORD_BITS-1:0]  mem_rdata,
    input  logic                  mem_ready
`ifdef CACHE_LINE_CTRL_PERF_EN
    ,
    output logic [31:0]           miss_count,
    output logic [31:0]           wb_count
`endif
);

    clc_state_t state, state_nx;

    logic [ADDR_W-OFF_W-1:0]                 req_line_q;
    logic [ADDR_W-OFF_W-1:0]                 vic_addr_q;
    logic [LINE_WORDS-1:0][WORD_BITS-1:0]    vic_q;
    logic [LINE_WORDS-1:0][WORD_BITS-1:0]    fill_q;
    logic [CNT_W-1:0]                        cnt;
    logic                                    last;
    logic                                    beat;
    logic                                    miss;
    logic                                    unused_addr_bits;

    // Byte offset of the request is irrelevant: the whole line is fetched.
    assign unused_addr_bits = ^req_addr[OFF_W-1:0];

    assign miss      = req_valid & ~hit;
    assign stall     = (state != IDLE) | miss;
    assign beat      = mem_ready & ((state == WB) | (state == FILL));
    assign fill_line = fill_q;

    line_beat_counter #(.WORDS(LINE_WORDS), .CNT_W(CNT_W)) u_beat_cnt (
        .clk   (clk),
        .reset (reset),
        .adv   (beat),
        .cnt   (cnt),
        .last  (last)
    );

    // State register; reset abandons any sequence in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    // Next state and memory-port drive; outputs are pure functions of state
    // and latched data so they hold steady across wait states.
    always_comb begin
        state_nx   = state;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        fill_valid = 1'b0;
        case (state)
            IDLE: if (miss) state_nx = dirty ? WB : FILL;
            WB: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {vic_addr_q, cnt, 2'b00};
                mem_wdata = vic_q[cnt];
                if (mem_ready && last) state_nx = FILL;
            end
            FILL: begin
                mem_req  = 1'b1;
                mem_addr = {req_line_q, cnt, 2'b00};
                if (mem_ready && last) state_nx = DONE;
            end
            DONE: begin
                fill_valid = 1'b1;
                state_nx   = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Capture the missing request (and dirty victim) when the miss is accepted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_line_q <= '0;
            vic_addr_q <= '0;
            vic_q      <= '0;
        end else if (state == IDLE && miss) begin
            req_line_q <= req_addr[ADDR_W-1:OFF_W];
            if (dirty) begin
                vic_addr_q <= victim_line_addr;
                vic_q      <= victim_line;
            end
        end
    end

    // Assemble the refill line word by word as read beats complete.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                          fill_q      <= '0;
        else if (state == FILL && mem_ready) fill_q[cnt] <= mem_rdata;
    end

`ifdef CACHE_LINE_CTRL_PERF_EN
    // Saturating event counters: misses accepted and victims written back.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            miss_count <= '0;
            wb_count   <= '0;
        end else begin
            if (state == IDLE && state_nx != IDLE && miss_count != '1)
                miss_count <= miss_count + 32'd1;
            if (state == WB && state_nx == FILL && wb_count != '1)
                wb_count <= wb_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cache_line_controller.sv
// Directed bench for cache_line_controller with a beat/line scoreboard and a
// memory responder that can insert wait states before every beat.
module tb_cache_line_controller;

    logic         clk = 1'b0;
    logic         reset;
    logic         req_valid;
    logic [31:0]  req_addr;
    logic         hit;
    logic         dirty;
    logic [27:0]  victim_line_addr;
    logic [127:0] victim_line;
    logic         stall;
    logic [127:0] fill_line;
    logic         fill_valid;
    logic [31:0]  mem_addr;
    logic [31:0]  mem_wdata;
    logic         mem_req;
    logic         mem_we;
    logic [31:0]  mem_rdata;
    logic         mem_ready;
`ifdef CACHE_LINE_CTRL_PERF_EN
    logic [31:0]  miss_count;
    logic [31:0]  wb_count;
`endif

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
    } beat_t;

    beat_t        beat_q[$];
    logic [127:0] line_q[$];

    int checks = 0;
    int errors = 0;
    int wait_n = 0;
    int wcnt   = 0;
    int stall_n, fill_n, fill_at;
    logic        held = 1'b0;
    logic [31:0] hold_addr, hold_wdata;

    always #5 clk = ~clk;

    // Memory model: words 0x11..0x44 at 0x20..0x2C, address-tagged elsewhere.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a >= 32'h20 && a <= 32'h2C) return (((a - 32'h20) >> 2) + 32'd1) * 32'h11;
        return 32'hD000_0000 | a;
    endfunction

    assign mem_rdata = mem_word(mem_addr);

    cache_line_controller dut (
        .clk              (clk),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_addr         (req_addr),
        .hit              (hit),
        .dirty            (dirty),
        .victim_line_addr (victim_line_addr),
        .victim_line      (victim_line),
        .stall            (stall),
        .fill_line        (fill_line),
        .fill_valid       (fill_valid),
        .mem_addr         (mem_addr),
        .mem_wdata        (mem_wdata),
        .mem_req          (mem_req),
        .mem_we           (mem_we),
        .mem_rdata        (mem_rdata),
        .mem_ready        (mem_ready)
`ifdef CACHE_LINE_CTRL_PERF_EN
        ,
        .miss_count       (miss_count),
        .wb_count         (wb_count)
`endif
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle, entered and left at posedge+1: respond to the memory
    // port, score completed beats and fill strobes, then advance the clock.
    task automatic cyc();
        beat_t        b;
        logic [127:0] ln;
        if (held) begin
            chk("hold_req", {127'd0, mem_req}, 128'd1);
            chk("hold_addr", {96'd0, mem_addr}, {96'd0, hold_addr});
            chk("hold_wdata", {96'd0, mem_wdata}, {96'd0, hold_wdata});
        end
        if (mem_req) begin
            mem_ready = (wcnt == wait_n);
            wcnt      = mem_ready ? 0 : wcnt + 1;
        end else begin
            mem_ready = 1'b0;
            wcnt      = 0;
        end
        #1;
        if (stall) stall_n++;
        if (mem_req && mem_ready) begin
            if (beat_q.size() == 0) chk("beat_unexpected", 128'd1, 128'd0);
            else begin
                b = beat_q.pop_front();
                chk("beat_addr", {96'd0, mem_addr}, {96'd0, b.addr});
                chk("beat_we", {127'd0, mem_we}, {127'd0, b.we});
                if (b.we) chk("beat_wdata", {96'd0, mem_wdata}, {96'd0, b.wdata});
            end
        end
        if (fill_valid) begin
            fill_n++;
            fill_at = stall_n;
            if (line_q.size() == 0) chk("fill_unexpected", 128'd1, 128'd0);
            else begin
                ln = line_q.pop_front();
                chk("fill_line", fill_line, ln);
            end
        end
        held       = mem_req && !mem_ready;
        hold_addr  = mem_addr;
        hold_wdata = mem_wdata;
        @(posedge clk); #1;
    endtask

    // Push the expected beats for one miss sequence (and optionally its line).
    task automatic push_miss(input logic [31:0] addr, input logic d, input logic [27:0] vaddr,
                             input logic [127:0] vline, input logic with_line);
        beat_t        b;
        logic [127:0] ln;
        logic [31:0]  base;
        if (d) begin
            for (int i = 0; i < 4; i++) begin
                b.addr  = {vaddr, 4'h0} + 32'(4 * i);
                b.we    = 1'b1;
                b.wdata = vline[32*i +: 32];
                beat_q.push_back(b);
            end
        end
        base = addr & ~32'hF;
        for (int i = 0; i < 4; i++) begin
            b.addr  = base + 32'(4 * i);
            b.we    = 1'b0;
            b.wdata = 32'h0;
            ln[32*i +: 32] = mem_word(b.addr);
            beat_q.push_back(b);
        end
        if (with_line) line_q.push_back(ln);
    endtask

    // Full miss: present it for one cycle, scramble request inputs, run to IDLE.
    task automatic do_miss(input string tag, input logic [31:0] addr, input logic d,
                           input logic [27:0] vaddr, input logic [127:0] vline,
                           input int wn, input int exp_stall);
        int n;
        push_miss(addr, d, vaddr, vline, 1'b1);
        wait_n = wn;
        req_valid = 1'b1; req_addr = addr; hit = 1'b0; dirty = d;
        victim_line_addr = vaddr; victim_line = vline;
        #1;
        chk({tag, "_stall_same_cycle"}, {127'd0, stall}, 128'd1);
        cyc();
        req_valid = 1'b0; req_addr = 32'hFFFF_FFF0; dirty = ~d; hit = 1'b1;
        victim_line_addr = 28'hFFF_FFFF; victim_line = '1;
        stall_n = 0; fill_n = 0; fill_at = -1; n = 0;
        while (stall && n < 300) begin
            cyc();
            n++;
        end
        chk({tag, "_timeout"}, {127'd0, stall}, 128'd0);
        chk({tag, "_stall_cycles"}, 128'(stall_n), 128'(exp_stall));
        chk({tag, "_fill_count"}, 128'(fill_n), 128'd1);
        chk({tag, "_fill_cycle"}, 128'(fill_at), 128'(exp_stall));
        chk({tag, "_beats_left"}, 128'(beat_q.size()), 128'd0);
        chk({tag, "_lines_left"}, 128'(line_q.size()), 128'd0);
    endtask

    initial begin
        reset = 1'b0; req_valid = 1'b0; req_addr = '0; hit = 1'b0; dirty = 1'b0;
        victim_line_addr = '0; victim_line = '0; mem_ready = 1'b0;
        #3;
        chk("rst_stall", {127'd0, stall}, 128'd0);
        chk("rst_mem_req", {127'd0, mem_req}, 128'd0);
        chk("rst_mem_we", {127'd0, mem_we}, 128'd0);
        chk("rst_mem_addr", {96'd0, mem_addr}, 128'd0);
        chk("rst_mem_wdata", {96'd0, mem_wdata}, 128'd0);
        chk("rst_fill_line", fill_line, 128'd0);
        chk("rst_fill_valid", {127'd0, fill_valid}, 128'd0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b1;

        // Hits never stall or touch memory, even with a stray mem_ready.
        req_valid = 1'b1; hit = 1'b1; req_addr = 32'h0000_0040; mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("hit_stall", {127'd0, stall}, 128'd0);
            chk("hit_mem_req", {127'd0, mem_req}, 128'd0);
            chk("hit_fill_valid", {127'd0, fill_valid}, 128'd0);
            @(posedge clk); #1;
        end
        req_valid = 1'b0; hit = 1'b0; mem_ready = 1'b0;

        // Clean miss abandoned by reset after two read beats.
        push_miss(32'h0000_0044, 1'b0, 28'h0, 128'h0, 1'b0);
        wait_n = 0;
        req_valid = 1'b1; req_addr = 32'h0000_0044; hit = 1'b0; dirty = 1'b0;
        cyc();
        req_valid = 1'b0;
        cyc();
        cyc();
        reset = 1'b0;
        #1;
        chk("abort_stall", {127'd0, stall}, 128'd0);
        chk("abort_mem_req", {127'd0, mem_req}, 128'd0);
        chk("abort_fill_valid", {127'd0, fill_valid}, 128'd0);
        chk("abort_fill_line", fill_line, 128'd0);
        beat_q.delete();
        @(posedge clk); @(posedge clk); #1;
        chk("abort_no_fill", {127'd0, fill_valid}, 128'd0);
        reset = 1'b1; mem_ready = 1'b0; held = 1'b0;

        // Clean miss, zero-wait: first beat at offset 0 confirms restart.
        do_miss("clean", 32'h0000_0024, 1'b0, 28'h0, 128'h0, 0, 5);
        chk("clean_line_const", fill_line, 128'h00000044_00000033_00000022_00000011);

        // Dirty miss, zero-wait: 4 writebacks then 4 reads.
        do_miss("dirty", 32'h0000_0100, 1'b1, 28'h000_0003,
                128'h000000A3_000000A2_000000A1_000000A0, 0, 9);

        // Dirty miss with 2 wait cycles before every beat: 8 beats * 3 + DONE.
        do_miss("dirty_wait", 32'h0000_0200, 1'b1, 28'h000_0007,
                128'hB3B3B3B3_B2B2B2B2_B1B1B1B1_B0B0B0B0, 2, 25);

`ifdef CACHE_LINE_CTRL_PERF_EN
        chk("perf_miss_count", {96'd0, miss_count}, 128'd3);
        chk("perf_wb_count", {96'd0, wb_count}, 128'd2);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
